// File: rtl/clkdiv_monitor.sv
// Period / high-time / ratio monitor for a divided clock that is synchronous to clk.
// Optional duty-cycle qualification of lock is built when CLKDIV_MON_DUTY_EN is defined.
module clkdiv_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_vld,
  output logic [3:0]       ratio_log2,
  output logic             locked,
  output logic             err
);

  localparam logic [0:0]       S_IDLE    = 1'b0;
  localparam logic [0:0]       S_MEAS    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       MATCH_MAX = 4'(LOCK_CNT);

  logic [0:0]       state_q, state_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [3:0]       ratio_q, ratio_d;
  logic             vld_q, vld_d;
  logic [3:0]       match_q, match_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             rise;
  logic             duty_ok;
  logic             meas_ok;

  function automatic logic [3:0] log2_pow2(input logic [CNT_W-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 1; i < CNT_W; i++) begin
      if (v == (CNT_ONE << i)) r = 4'(i);
    end
    return r;
  endfunction

`ifdef CLKDIV_MON_DUTY_EN
  localparam logic [CNT_W:0] EXT_ONE = (CNT_W + 1)'(1);

  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic [CNT_W:0]   cyc_ext;
  logic [CNT_W:0]   hi_ext;

  // Accept either rounding of half the period so odd divisors still qualify.
  assign cyc_ext   = {1'b0, cyc_q};
  assign hi_ext    = {1'b0, hi_q};
  assign duty_ok   = (hi_ext == (cyc_ext >> 1)) || (hi_ext == ((cyc_ext + EXT_ONE) >> 1));
  assign high_time = high_time_q;
`else
  assign duty_ok   = 1'b1;
  assign high_time = '0;
`endif

  assign rise    = div_in & ~div_q;
  assign meas_ok = duty_ok && ((match_q == 4'd0) || (cyc_q == period_q));

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves one unassigned (no latch).
    state_d  = state_q;
    div_d    = div_in;
    cyc_d    = cyc_q;
    period_d = period_q;
    ratio_d  = ratio_q;
    vld_d    = 1'b0;
    match_d  = match_q;
    locked_d = locked_q;
    err_d    = err_q;
`ifdef CLKDIV_MON_DUTY_EN
    hi_d        = hi_q;
    high_time_d = high_time_q;
`endif

    if (!en) begin
      state_d  = S_IDLE;
      cyc_d    = '0;
      match_d  = 4'd0;
      locked_d = 1'b0;
`ifdef CLKDIV_MON_DUTY_EN
      hi_d     = '0;
`endif
    end else begin
      cyc_d = rise ? CNT_ONE : cyc_q + CNT_ONE;
`ifdef CLKDIV_MON_DUTY_EN
      hi_d  = rise ? CNT_ONE : hi_q + CNT_W'(div_in);
`endif
      case (state_q)
        S_IDLE: begin
          if (rise) state_d = S_MEAS;
        end
        default: begin
          if (rise) begin
            // Rise wins over a simultaneous overflow, so a full-scale period is still reported.
            period_d = cyc_q;
            ratio_d  = log2_pow2(cyc_q);
            vld_d    = 1'b1;
`ifdef CLKDIV_MON_DUTY_EN
            high_time_d = hi_q;
`endif
            if (meas_ok) begin
              match_d = (match_q >= MATCH_MAX) ? MATCH_MAX : match_q + 4'd1;
              if (match_d == MATCH_MAX) locked_d = 1'b1;
            end else begin
              match_d = 4'd1;
              if (locked_q) begin
                locked_d = 1'b0;
                err_d    = 1'b1;
              end
            end
          end else if (cyc_q == CNT_MAX) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = 4'd0;
            state_d  = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= 1'b0;
      cyc_q    <= '0;
      period_q <= '0;
      ratio_q  <= 4'd0;
      vld_q    <= 1'b0;
      match_q  <= 4'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef CLKDIV_MON_DUTY_EN
      hi_q        <= '0;
      high_time_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cyc_q    <= cyc_d;
      period_q <= period_d;
      ratio_q  <= ratio_d;
      vld_q    <= vld_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      err_q    <= err_d;
`ifdef CLKDIV_MON_DUTY_EN
      hi_q        <= hi_d;
      high_time_q <= high_time_d;
`endif
    end
  end

  assign period     = period_q;
  assign ratio_log2 = ratio_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Scoreboard bench for clkdiv_monitor: stimulus pushes hand-computed reports, a negedge monitor pops them.
// Expected high_time and duty-lock behaviour follow CLKDIV_MON_DUTY_EN.
module tb_clkdiv_monitor;
  localparam int CNT_W = 8;
  localparam int LOCK  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             div_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_vld;
  logic [3:0]       ratio_log2;
  logic             locked;
  logic             err;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [3:0]       ratio;
    logic             locked;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  clkdiv_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .period     (period),
    .high_time  (high_time),
    .period_vld (period_vld),
    .ratio_log2 (ratio_log2),
    .locked     (locked),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int eh(input int h);
`ifdef CLKDIV_MON_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  function automatic bit duty_build();
`ifdef CLKDIV_MON_DUTY_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push(input int p, input int h, input int r, input bit lk, input bit er);
    exp_t e;
    e.period = CNT_W'(p);
    e.high   = CNT_W'(h);
    e.ratio  = 4'(r);
    e.locked = lk;
    e.err    = er;
    exp_q.push_back(e);
  endtask

  // Inputs change at negedge; on return the outputs reflect the posedge that sampled v.
  task automatic tick(input logic v);
    div_in = v;
    @(negedge clk);
  endtask

  task automatic drive(input int p, input int h, input int n, input bit chk_lat);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < p; j++) begin
        tick(j < h);
        if (chk_lat && i == 0 && j == p - 1) check("no_vld_before_2nd_rise", period_vld, 0);
        if (chk_lat && i == 1 && j == 0) check("first_vld_latency", period_vld, 1);
      end
    end
  endtask

  task automatic run_phase(input int p, input int h, input int r, input int n, input bit chk_lat);
    for (int k = 1; k <= n; k++) push(p, eh(h), r, k >= LOCK, 1'b0);
    en = 1'b1;
    drive(p, h, n, chk_lat);
    tick(1'b1);
    en = 1'b0;
    repeat (3) tick(1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high_time"}, high_time, 0);
    check({tag, "_ratio"}, ratio_log2, 0);
    check({tag, "_vld"}, period_vld, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (period_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_vld", period_vld, 0);
      end else begin
        e = exp_q.pop_front();
        check("period", period, e.period);
        check("high_time", high_time, e.high);
        check("ratio_log2", ratio_log2, e.ratio);
        check("locked", locked, e.locked);
        check("err", err, e.err);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    div_in = 1'b0;
    repeat (3) tick(1'b0);
    check_zero("reset");
    rst = 1'b0;
    tick(1'b0);

    // Steady divisors: power-of-two and non-power-of-two.
    run_phase(4, 2, 2, 5, 1'b1);
    run_phase(16, 8, 4, 5, 1'b0);
    run_phase(6, 3, 0, 5, 1'b0);

    // Lock on 8, one period of 12, then relock on 8.
    for (int k = 1; k <= 4; k++) push(8, eh(4), 3, k == 4, 1'b0);
    push(12, eh(6), 0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) push(8, eh(4), 3, k == 4, 1'b1);
    en = 1'b1;
    drive(8, 4, 4, 1'b0);
    drive(12, 6, 1, 1'b0);
    drive(8, 4, 4, 1'b0);
    tick(1'b1);
    en = 1'b0;
    repeat (3) tick(1'b0);
    check("err_sticky_after_lock_loss", err, 1);
    check("locked_cleared_by_en", locked, 0);

    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    tick(1'b0);
    check("err_cleared_by_rst", err, 0);

    // Reset mid-period while locked.
    for (int k = 1; k <= 5; k++) push(8, eh(4), 3, k >= LOCK, 1'b0);
    en = 1'b1;
    drive(8, 4, 5, 1'b0);
    tick(1'b1);
    check("locked_before_rst", locked, 1);
    tick(1'b1);
    tick(1'b1);
    rst = 1'b1;
    tick(1'b0);
    check_zero("mid_period_rst");
    rst = 1'b0;

    // Overflow: div_in stuck high in MEAS, then recovery with err held.
    tick(1'b0);
    tick(1'b0);
    push(8, eh(4), 3, 1'b0, 1'b0);
    push(8, eh(4), 3, 1'b0, 1'b0);
    drive(8, 4, 2, 1'b0);
    repeat (300) tick(1'b1);
    check("overflow_err", err, 1);
    check("overflow_locked", locked, 0);
    check("overflow_period_held", period, 8);
    check("overflow_no_vld", period_vld, 0);
    repeat (4) tick(1'b0);
    for (int k = 1; k <= 3; k++) push(4, eh(2), 2, 1'b0, 1'b1);
    drive(4, 2, 3, 1'b0);
    tick(1'b1);
    en = 1'b0;
    repeat (3) tick(1'b0);
    check("err_held_after_resume", err, 1);

    // Period 8 with 5 high: duty failure in the duty build, ordinary lock otherwise.
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    tick(1'b0);
    for (int k = 1; k <= 5; k++) push(8, eh(5), 3, !duty_build() && k >= LOCK, 1'b0);
    en = 1'b1;
    drive(8, 5, 5, 1'b0);
    tick(1'b1);
    en = 1'b0;
    repeat (3) tick(1'b0);

    // Full-scale period: rise coincides with cyc reaching its maximum.
    run_phase(255, 128, 0, 2, 1'b0);

    repeat (5) tick(1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
